// File: rtl/arch_maptable_pkg.sv
// Shared definitions for the architectural map table and its neighbours:
// sizing macros, tag/register types, CDB and rename-map types, retire packet
// and the recovery FSM state encoding.
`ifndef WIDTH
`define WIDTH 2
`endif
`ifndef RF_SIZE
`define RF_SIZE 32
`endif
`ifndef PRF_SIZE
`define PRF_SIZE 64
`endif
`ifndef ZERO_REG
`define ZERO_REG 0
`endif

package arch_maptable_pkg;

    localparam int REG_W  = $clog2(`RF_SIZE);
    localparam int TAG_W  = $clog2(`PRF_SIZE);
    localparam int SLOT_W = (`WIDTH > 1) ? $clog2(`WIDTH) : 1;

    typedef logic [REG_W-1:0] areg_t;
    typedef logic [TAG_W-1:0] ptag_t;

    // Common data bus broadcast of a completed physical tag.
    typedef struct packed {
        logic  valid;
        ptag_t tag;
    } cdb_packet_t;

    // One speculative rename map entry.
    typedef struct packed {
        ptag_t tag;
        logic  ready;
    } mapt_entry_t;

    // Recovery FSM of the architectural map.
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RECOVER = 1'b1
    } amt_state_t;

    // One retirement slot as seen by the architectural map.
    typedef struct packed {
        logic  valid;
        areg_t dest;
        ptag_t t;
        ptag_t told;
        logic  mispredict;
        logic  exception;
    } retire_pkt_t;

    function automatic logic is_zero_reg(input areg_t r);
        return r == areg_t'(`ZERO_REG);
    endfunction

endpackage

// File: rtl/arch_maptable_retire_filter.sv
// Combinational retire-slot filter: a slot is effective when it is valid and
// no older valid slot in the same group is a mispredict or exception. The
// oldest such flagged slot is reported as the recovery trigger.
module retire_filter
    import arch_maptable_pkg::*;
(
    input  logic [`WIDTH-1:0] valid,
    input  logic [`WIDTH-1:0] mispredict,
    input  logic [`WIDTH-1:0] exception,
    output logic [`WIDTH-1:0] eff_mask,
    output logic              trigger,
    output logic [SLOT_W-1:0] trig_slot
);

    logic [`WIDTH-1:0] flagged;
    logic [`WIDTH:0]   blocked;

    assign blocked[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < `WIDTH; gi++) begin : g_slot
            assign flagged[gi]    = valid[gi] & (mispredict[gi] | exception[gi]);
            assign eff_mask[gi]   = valid[gi] & ~blocked[gi];
            assign blocked[gi+1]  = blocked[gi] | flagged[gi];
        end
    endgenerate

    assign trigger = blocked[`WIDTH];

    // Lowest-numbered flagged slot wins (scan from the top so the oldest is kept last).
    always_comb begin
        trig_slot = '0;
        for (int k = `WIDTH - 1; k >= 0; k--) begin
            if (flagged[k]) begin
                trig_slot = SLOT_W'(k);
            end
        end
    end

endmodule

// File: rtl/arch_maptable.sv
// Architectural (committed) register map. Retiring slots update the map and
// return their previous tags to the free list; a retiring mispredict or
// exception triggers a one-cycle recovery pulse toward the rename map.
module arch_maptable
    import arch_maptable_pkg::*;
(
    input  logic                               clock,
    input  logic                               reset,
    input  logic [`WIDTH-1:0]                  retire_valid,
    input  logic [`WIDTH-1:0][REG_W-1:0]       retire_dest,
    input  logic [`WIDTH-1:0][TAG_W-1:0]       retire_T,
    input  logic [`WIDTH-1:0][TAG_W-1:0]       retire_Told,
    input  logic [`WIDTH-1:0]                  retire_mispredict,
    input  logic [`WIDTH-1:0]                  retire_exception,
    output logic [`RF_SIZE-1:0][TAG_W-1:0]     rec_tag,
    output logic                               rollback_en,
    output logic                               exception_en,
    output logic [REG_W-1:0]                   rollback_reg,
    output logic [TAG_W-1:0]                   rollback_tag,
    output logic [`WIDTH-1:0]                  free_valid,
    output logic [`WIDTH-1:0][TAG_W-1:0]       free_tag,
    output logic                               retire_ready
);

    retire_pkt_t [`WIDTH-1:0] pkt;
    logic [`WIDTH-1:0]        pkt_valid;
    logic [`WIDTH-1:0]        pkt_mis;
    logic [`WIDTH-1:0]        pkt_exc;
    logic [`WIDTH-1:0]        eff_mask;
    logic [`WIDTH-1:0]        eff_idle;
    logic                     trigger;
    logic [SLOT_W-1:0]        trig_slot;
    logic                     idle;

    amt_state_t                   state_q, state_d;
    logic [`RF_SIZE-1:0][TAG_W-1:0] map_q, map_d;
    logic                         rollback_en_q, rollback_en_d;
    logic                         exception_en_q, exception_en_d;
    logic [REG_W-1:0]             rollback_reg_q, rollback_reg_d;
    logic [TAG_W-1:0]             rollback_tag_q, rollback_tag_d;

    genvar gi;
    generate
        for (gi = 0; gi < `WIDTH; gi++) begin : g_pkt
            assign pkt[gi].valid      = retire_valid[gi];
            assign pkt[gi].dest       = retire_dest[gi];
            assign pkt[gi].t          = retire_T[gi];
            assign pkt[gi].told       = retire_Told[gi];
            assign pkt[gi].mispredict = retire_mispredict[gi];
            assign pkt[gi].exception  = retire_exception[gi];
            assign pkt_valid[gi]      = pkt[gi].valid;
            assign pkt_mis[gi]        = pkt[gi].mispredict;
            assign pkt_exc[gi]        = pkt[gi].exception;
        end
    endgenerate

    retire_filter u_filter (
        .valid      (pkt_valid),
        .mispredict (pkt_mis),
        .exception  (pkt_exc),
        .eff_mask   (eff_mask),
        .trigger    (trigger),
        .trig_slot  (trig_slot)
    );

    // Retire inputs only count while idle; recovery cycles ignore them.
    assign idle     = (state_q == ST_IDLE);
    assign eff_idle = eff_mask & {`WIDTH{idle}};

    // Each effective slot writing a real register frees its old tag; the
    // same condition is the map write enable.
    generate
        for (gi = 0; gi < `WIDTH; gi++) begin : g_free
            assign free_valid[gi] = eff_idle[gi] & ~is_zero_reg(pkt[gi].dest);
            assign free_tag[gi]   = free_valid[gi] ? pkt[gi].told : '0;
        end
    endgenerate

    // Map update in program order so the younger slot wins a shared dest.
    always_comb begin
        map_d = map_q;
        for (int k = 0; k < `WIDTH; k++) begin
            if (free_valid[k]) begin
                map_d[pkt[k].dest] = pkt[k].t;
            end
        end
        map_d[`ZERO_REG] = '0;
    end

    // Recovery FSM next state and registered recovery outputs.
    always_comb begin
        state_d        = state_q;
        rollback_en_d  = 1'b0;
        exception_en_d = 1'b0;
        rollback_reg_d = rollback_reg_q;
        rollback_tag_d = rollback_tag_q;
        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    state_d        = ST_RECOVER;
                    rollback_en_d  = 1'b1;
                    exception_en_d = pkt[trig_slot].exception;
                    rollback_reg_d = pkt[trig_slot].dest;
                    rollback_tag_d = pkt[trig_slot].t;
                end
            end
            ST_RECOVER: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset restores the identity map and drops any pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            rollback_en_q  <= 1'b0;
            exception_en_q <= 1'b0;
            rollback_reg_q <= '0;
            rollback_tag_q <= '0;
            for (int i = 0; i < `RF_SIZE; i++) begin
                map_q[i] <= TAG_W'(i);
            end
        end else begin
            state_q        <= state_d;
            rollback_en_q  <= rollback_en_d;
            exception_en_q <= exception_en_d;
            rollback_reg_q <= rollback_reg_d;
            rollback_tag_q <= rollback_tag_d;
            map_q          <= map_d;
        end
    end

    assign rec_tag      = map_q;
    assign rollback_en  = rollback_en_q;
    assign exception_en = exception_en_q;
    assign rollback_reg = rollback_reg_q;
    assign rollback_tag = rollback_tag_q;
    assign retire_ready = idle;

endmodule

// File: tb/tb_arch_maptable.sv
// Scoreboard bench for arch_maptable: stimulus pushes cycle-stamped
// expectations, a negedge monitor pops and compares them.
module tb_arch_maptable;
    import arch_maptable_pkg::*;

    logic                           clock = 1'b0;
    logic                           reset = 1'b1;
    logic [`WIDTH-1:0]              retire_valid;
    logic [`WIDTH-1:0][REG_W-1:0]   retire_dest;
    logic [`WIDTH-1:0][TAG_W-1:0]   retire_T;
    logic [`WIDTH-1:0][TAG_W-1:0]   retire_Told;
    logic [`WIDTH-1:0]              retire_mispredict;
    logic [`WIDTH-1:0]              retire_exception;
    logic [`RF_SIZE-1:0][TAG_W-1:0] rec_tag;
    logic                           rollback_en;
    logic                           exception_en;
    logic [REG_W-1:0]               rollback_reg;
    logic [TAG_W-1:0]               rollback_tag;
    logic [`WIDTH-1:0]              free_valid;
    logic [`WIDTH-1:0][TAG_W-1:0]   free_tag;
    logic                           retire_ready;

    arch_maptable dut (
        .clock             (clock),
        .reset             (reset),
        .retire_valid      (retire_valid),
        .retire_dest       (retire_dest),
        .retire_T          (retire_T),
        .retire_Told       (retire_Told),
        .retire_mispredict (retire_mispredict),
        .retire_exception  (retire_exception),
        .rec_tag           (rec_tag),
        .rollback_en       (rollback_en),
        .exception_en      (exception_en),
        .rollback_reg      (rollback_reg),
        .rollback_tag      (rollback_tag),
        .free_valid        (free_valid),
        .free_tag          (free_tag),
        .retire_ready      (retire_ready)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef enum int {K_REC, K_RBEN, K_EXC, K_RBREG, K_RBTAG, K_FV, K_FT, K_RDY} kind_t;
    typedef struct {
        int    cyc;
        kind_t kind;
        int    idx;
        int    exp;
        string name;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    function automatic void expect_at(input int c, input kind_t k, input int idx,
                                      input int v, input string nm);
        exp_t e;
        e.cyc  = c;
        e.kind = k;
        e.idx  = idx;
        e.exp  = v;
        e.name = nm;
        sb.push_back(e);
    endfunction

    function automatic int actual(input kind_t k, input int idx);
        case (k)
            K_REC:   return int'(rec_tag[idx]);
            K_RBEN:  return int'(rollback_en);
            K_EXC:   return int'(exception_en);
            K_RBREG: return int'(rollback_reg);
            K_RBTAG: return int'(rollback_tag);
            K_FV:    return int'(free_valid);
            K_FT:    return int'(free_tag[idx]);
            K_RDY:   return int'(retire_ready);
            default: return -1;
        endcase
    endfunction

    // Monitor: at each negedge compare every expectation due this cycle.
    always @(negedge clock) begin
        int i;
        int a;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc <= cyc) begin
                a = actual(sb[i].kind, sb[i].idx);
                tests++;
                if (sb[i].cyc < cyc) begin
                    fails++;
                    $display("FAIL %s: check missed its cycle %0d (now %0d)", sb[i].name, sb[i].cyc, cyc);
                end else if (a != sb[i].exp) begin
                    fails++;
                    $display("FAIL %s: got %0d expected %0d (cycle %0d)", sb[i].name, a, sb[i].exp, cyc);
                end
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic drive_idle();
        retire_valid      = '0;
        retire_mispredict = '0;
        retire_exception  = '0;
        retire_dest       = '0;
        retire_T          = '0;
        retire_Told       = '0;
    endtask

    // Drive one retire group for one cycle, starting just after a posedge.
    task automatic issue(input logic [1:0] v, input logic [1:0] m, input logic [1:0] e,
                         input int d0, input int d1, input int t0, input int t1,
                         input int o0, input int o1);
        @(posedge clock);
        #1;
        retire_valid      = v;
        retire_mispredict = m;
        retire_exception  = e;
        retire_dest[0]    = REG_W'(d0);
        retire_dest[1]    = REG_W'(d1);
        retire_T[0]       = TAG_W'(t0);
        retire_T[1]       = TAG_W'(t1);
        retire_Told[0]    = TAG_W'(o0);
        retire_Told[1]    = TAG_W'(o1);
        $display("[TB] cycle %0d retire v=%b m=%b e=%b s0 r%0d T%0d Told%0d s1 r%0d T%0d Told%0d",
                 cyc, v, m, e, d0, t0, o0, d1, t1, o1);
    endtask

    task automatic idle_cycle();
        @(posedge clock);
        #1;
        drive_idle();
    endtask

    initial begin
        int c;
        drive_idle();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        c = cyc;
        $display("[TB] cycle %0d reset released", c);
        for (int i = 0; i < `RF_SIZE; i++) begin
            expect_at(c, K_REC, i, i, $sformatf("reset_rec_tag[%0d]", i));
        end
        expect_at(c, K_RBEN, 0, 0, "reset_rollback_en");
        expect_at(c, K_EXC, 0, 0, "reset_exception_en");
        expect_at(c, K_RDY, 0, 1, "reset_retire_ready");
        expect_at(c, K_RBREG, 0, 0, "reset_rollback_reg");
        expect_at(c, K_RBTAG, 0, 0, "reset_rollback_tag");
        expect_at(c, K_FV, 0, 0, "reset_free_valid");

        // Two independent retires.
        issue(2'b11, 2'b00, 2'b00, 3, 5, 40, 41, 3, 5);
        c = cyc;
        expect_at(c, K_FV, 0, 3, "t1_free_valid");
        expect_at(c, K_FT, 0, 3, "t1_free_tag0");
        expect_at(c, K_FT, 1, 5, "t1_free_tag1");
        expect_at(c + 1, K_REC, 3, 40, "t1_rec_tag3");
        expect_at(c + 1, K_REC, 5, 41, "t1_rec_tag5");

        // Same dest in both slots: younger wins, both old tags freed.
        issue(2'b11, 2'b00, 2'b00, 7, 7, 42, 43, 7, 42);
        c = cyc;
        expect_at(c, K_FV, 0, 3, "t2_free_valid");
        expect_at(c, K_FT, 0, 7, "t2_free_tag0");
        expect_at(c, K_FT, 1, 42, "t2_free_tag1");
        expect_at(c + 1, K_REC, 7, 43, "t2_rec_tag7");

        // Slot0 mispredict blocks slot1.
        issue(2'b11, 2'b01, 2'b00, 1, 2, 50, 51, 1, 2);
        c = cyc;
        expect_at(c, K_FV, 0, 1, "t3_free_valid");
        expect_at(c, K_FT, 0, 1, "t3_free_tag0");
        expect_at(c, K_FT, 1, 0, "t3_free_tag1");
        expect_at(c, K_RDY, 0, 1, "t3_ready_idle");
        expect_at(c + 1, K_REC, 1, 50, "t3_rec_tag1");
        expect_at(c + 1, K_REC, 2, 2, "t3_rec_tag2");
        expect_at(c + 1, K_RBEN, 0, 1, "t3_rollback_en");
        expect_at(c + 1, K_EXC, 0, 0, "t3_exception_en");
        expect_at(c + 1, K_RBREG, 0, 1, "t3_rollback_reg");
        expect_at(c + 1, K_RBTAG, 0, 50, "t3_rollback_tag");
        expect_at(c + 1, K_RDY, 0, 0, "t3_ready_recover");
        expect_at(c + 1, K_FV, 0, 0, "t3_free_valid_recover");
        expect_at(c + 2, K_REC, 6, 6, "t3_ignored_rec_tag6");
        expect_at(c + 2, K_RBEN, 0, 0, "t3_rollback_en_drop");
        expect_at(c + 2, K_RDY, 0, 1, "t3_ready_back");
        expect_at(c + 2, K_RBREG, 0, 1, "t3_rollback_reg_hold");
        // Retire attempt during RECOVER must be ignored.
        issue(2'b01, 2'b00, 2'b00, 6, 0, 55, 0, 6, 0);
        idle_cycle();

        // Slot1 exception, then reset during RECOVER.
        issue(2'b11, 2'b00, 2'b10, 8, 4, 52, 60, 8, 4);
        c = cyc;
        expect_at(c, K_FV, 0, 3, "t4_free_valid");
        expect_at(c + 1, K_RBEN, 0, 1, "t4_rollback_en");
        expect_at(c + 1, K_EXC, 0, 1, "t4_exception_en");
        expect_at(c + 1, K_RBREG, 0, 4, "t4_rollback_reg");
        expect_at(c + 1, K_RBTAG, 0, 60, "t4_rollback_tag");
        expect_at(c + 1, K_REC, 4, 60, "t4_rec_tag4");
        expect_at(c + 1, K_REC, 8, 52, "t4_rec_tag8");
        expect_at(c + 2, K_RBEN, 0, 0, "t4_reset_rollback_en");
        expect_at(c + 2, K_EXC, 0, 0, "t4_reset_exception_en");
        expect_at(c + 2, K_REC, 4, 4, "t4_reset_rec_tag4");
        expect_at(c + 2, K_REC, 8, 8, "t4_reset_rec_tag8");
        expect_at(c + 2, K_REC, 1, 1, "t4_reset_rec_tag1");
        expect_at(c + 2, K_RBREG, 0, 0, "t4_reset_rollback_reg");
        expect_at(c + 2, K_RDY, 0, 1, "t4_reset_ready");
        @(posedge clock);
        #1;
        drive_idle();
        reset = 1'b1;
        $display("[TB] cycle %0d reset asserted during recovery", cyc);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Retire to the zero register.
        issue(2'b11, 2'b00, 2'b00, 0, 9, 33, 34, 0, 9);
        c = cyc;
        expect_at(c, K_FV, 0, 2, "t5_free_valid");
        expect_at(c, K_FT, 0, 0, "t5_free_tag0");
        expect_at(c, K_FT, 1, 9, "t5_free_tag1");
        expect_at(c + 1, K_REC, 0, 0, "t5_rec_tag0");
        expect_at(c + 1, K_REC, 9, 34, "t5_rec_tag9");

        // Slot0 both mispredict and exception: exception wins.
        issue(2'b11, 2'b01, 2'b01, 12, 13, 63, 20, 12, 13);
        c = cyc;
        expect_at(c, K_FV, 0, 1, "t6_free_valid");
        expect_at(c, K_FT, 0, 12, "t6_free_tag0");
        expect_at(c + 1, K_RBEN, 0, 1, "t6_rollback_en");
        expect_at(c + 1, K_EXC, 0, 1, "t6_exception_en");
        expect_at(c + 1, K_RBREG, 0, 12, "t6_rollback_reg");
        expect_at(c + 1, K_RBTAG, 0, 63, "t6_rollback_tag");
        expect_at(c + 1, K_REC, 12, 63, "t6_rec_tag12");
        expect_at(c + 1, K_REC, 13, 13, "t6_rec_tag13");
        idle_cycle();

        repeat (4) idle_cycle();
        @(negedge clock);
        #1;
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
